// File: rtl/mem_word_ctrl.sv
// Word-to-byte memory controller: one 32-bit load/store becomes four byte accesses, little-endian.
// Latency: aligned response 5 cycles after accept, misaligned error 1 cycle; holds RESP until rsp_ready.
module mem_word_ctrl #(
    parameter int NBYTES = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              memwr,
    output logic              memrd,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        wrdata,
    input  logic [7:0]        rddata
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    localparam logic [1:0] LAST = 2'(NBYTES - 1);

    state_t            state, state_nxt;
    logic [1:0]        cnt;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-3:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              accept;
    logic              misaligned;

    assign accept     = (state == IDLE) && req_valid;
    assign misaligned = (req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        memwr     = 1'b0;
        memrd     = 1'b0;
        address   = '0;
        wrdata    = 8'h00;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = misaligned ? RESP : XFER;
                end
            end
            XFER: begin
                // base is word-aligned, so the byte offset simply fills the low bits
                address = {base_q, cnt};
                memwr   = we_q;
                memrd   = !we_q;
                if (we_q) begin
                    wrdata = wdata_q[{cnt, 3'b000} +: 8];
                end
                if (cnt == LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 2'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            base_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else if (accept) begin
            cnt     <= 2'd0;
            we_q    <= req_we;
            err_q   <= misaligned;
            base_q  <= req_addr[ADDR_W-1:2];
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
        end else if (state == XFER) begin
            cnt <= cnt + 2'd1;
            if (!we_q) begin
                rdata_q[{cnt, 3'b000} +: 8] <= rddata;
            end
        end
    end

endmodule
